// File: rtl/cds_data_pll_rst_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : cds_data_pll_rst_seq
// Function : PLL reset sequencer and lock supervisor for the CDS data-capture
//            PLL; releases data_rst only after lock has been stable.
// Revision : 1.0 - initial release
// ============================================================================
module cds_data_pll_rst_seq #(
    parameter int RST_PULSE_CYCLES    = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 262144,
    parameter int CNT_W               = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic             data_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam logic [1:0] c_ST_RESET_PLL = 2'd0;
    localparam logic [1:0] c_ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_ST_STABILIZE = 2'd2;
    localparam logic [1:0] c_ST_RUN       = 2'd3;

    localparam int c_MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                              RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_MAX    = (c_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                              c_MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int c_CYC_W  = $clog2(c_MAX + 1);

    localparam logic [c_CYC_W-1:0] c_RST_LAST = c_CYC_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CYC_W-1:0] c_STB_LAST = c_CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CYC_W-1:0] c_TO_LAST  = c_CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_SAT  = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    logic               r_meta_q,     w_meta_d;
    logic               r_locked_s_q, w_locked_s_d;
    logic [1:0]         r_state_q,    w_state_d;
    logic [c_CYC_W-1:0] r_cyc_q,      w_cyc_d;
    logic [CNT_W-1:0]   r_loss_q,     w_loss_d;
    logic [CNT_W-1:0]   r_to_q,       w_to_d;
    logic               r_pll_rst_q,  w_pll_rst_d;
    logic               r_data_rst_q, w_data_rst_d;
    logic               r_ready_q,    w_ready_d;
    logic               w_loss_inc;
    logic               w_to_inc;

    always_comb begin
        w_meta_d     = pll_locked;
        w_locked_s_d = r_meta_q;
        w_state_d    = r_state_q;
        w_cyc_d      = r_cyc_q + c_CYC_ONE;
        w_loss_inc   = 1'b0;
        w_to_inc     = 1'b0;

        case (r_state_q)
            c_ST_RESET_PLL: begin
                if (r_cyc_q == c_RST_LAST) begin
                    w_state_d = c_ST_WAIT_LOCK;
                end
            end
            c_ST_WAIT_LOCK: begin
                if (r_locked_s_q) begin
                    w_state_d = c_ST_STABILIZE;
                end else if (r_cyc_q == c_TO_LAST) begin
                    w_state_d = c_ST_RESET_PLL;
                    w_to_inc  = 1'b1;
                end
            end
            c_ST_STABILIZE: begin
                if (!r_locked_s_q) begin
                    w_state_d = c_ST_WAIT_LOCK;
                end else if (r_cyc_q == c_STB_LAST) begin
                    w_state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                // No dwell limit in RUN; hold the counter so it cannot wrap.
                w_cyc_d = r_cyc_q;
                if (!r_locked_s_q) begin
                    w_state_d  = c_ST_RESET_PLL;
                    w_loss_inc = 1'b1;
                end
            end
            default: begin
                w_state_d = c_ST_RESET_PLL;
            end
        endcase

        if (w_state_d != r_state_q) begin
            w_cyc_d = '0;
        end

        // Clear takes priority over a coincident increment.
        w_loss_d = r_loss_q;
        if (clr_cnt) begin
            w_loss_d = '0;
        end else if (w_loss_inc && (r_loss_q != c_CNT_SAT)) begin
            w_loss_d = r_loss_q + c_CNT_ONE;
        end

        w_to_d = r_to_q;
        if (clr_cnt) begin
            w_to_d = '0;
        end else if (w_to_inc && (r_to_q != c_CNT_SAT)) begin
            w_to_d = r_to_q + c_CNT_ONE;
        end

        w_pll_rst_d  = (w_state_d == c_ST_RESET_PLL);
        w_data_rst_d = (w_state_d != c_ST_RUN);
        w_ready_d    = (w_state_d == c_ST_RUN);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_meta_q     <= 1'b0;
            r_locked_s_q <= 1'b0;
            r_state_q    <= c_ST_RESET_PLL;
            r_cyc_q      <= '0;
            r_loss_q     <= '0;
            r_to_q       <= '0;
            r_pll_rst_q  <= 1'b1;
            r_data_rst_q <= 1'b1;
            r_ready_q    <= 1'b0;
        end else begin
            r_meta_q     <= w_meta_d;
            r_locked_s_q <= w_locked_s_d;
            r_state_q    <= w_state_d;
            r_cyc_q      <= w_cyc_d;
            r_loss_q     <= w_loss_d;
            r_to_q       <= w_to_d;
            r_pll_rst_q  <= w_pll_rst_d;
            r_data_rst_q <= w_data_rst_d;
            r_ready_q    <= w_ready_d;
        end
    end

    assign pll_rst       = r_pll_rst_q;
    assign data_rst      = r_data_rst_q;
    assign ready         = r_ready_q;
    assign state         = r_state_q;
    assign lock_loss_cnt = r_loss_q;
    assign timeout_cnt   = r_to_q;

endmodule
`default_nettype wire

// File: tb/tb_cds_data_pll_rst_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_cds_data_pll_rst_seq
// Function : Directed self-checking bench for cds_data_pll_rst_seq with an
//            edge-stamped expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cds_data_pll_rst_seq;

    localparam int RST_PULSE   = 64;
    localparam int LOCK_STABLE = 1024;
    localparam int LOCK_TO     = 100;
    localparam int CW          = 2;

    logic          refclk;
    logic          rst;
    logic          pll_locked;
    logic          clr_cnt;
    logic          pll_rst;
    logic          data_rst;
    logic          ready;
    logic [1:0]    state;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;

    cds_data_pll_rst_seq #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE),
        .LOCK_TIMEOUT_CYCLES (LOCK_TO),
        .CNT_W               (CW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .clr_cnt       (clr_cnt),
        .pll_rst       (pll_rst),
        .data_rst      (data_rst),
        .ready         (ready),
        .state         (state),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial refclk = 1'b0;
    always #2 refclk = ~refclk;

    typedef struct {
        int         edge_n;
        string      tag;
        logic [8:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   ecnt;
    int   n_assert;
    int   n_fail;
    int   r_run;

    // Expected outputs follow from the state: pll_rst in RESET_PLL,
    // data_rst outside RUN, ready only in RUN.
    task automatic push(input int e, input string tag, input logic [1:0] st,
                        input logic [CW-1:0] llc, input logic [CW-1:0] toc);
        exp_t it;
        it.edge_n = e;
        it.tag    = tag;
        it.exp    = {st, (st == 2'd0), (st != 2'd3), (st == 2'd3), llc, toc};
        sb_q.push_back(it);
    endtask

    task automatic check_edge();
        exp_t       it;
        logic [8:0] obs;
        while (sb_q.size() > 0 && sb_q[0].edge_n <= ecnt) begin
            it  = sb_q.pop_front();
            obs = {state, pll_rst, data_rst, ready, lock_loss_cnt, timeout_cnt};
            n_assert++;
            assert (it.edge_n == ecnt && obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: at edge %0d observed {st,prst,drst,rdy,llc,toc}=%b, expected %b at edge %0d",
                       it.tag, ecnt, obs, it.exp, it.edge_n);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (ecnt < target) begin
            @(posedge refclk);
            ecnt++;
            #1;
            check_edge();
        end
    endtask

    task automatic async_reset(input logic lock_lvl);
        rst = 1'b1;
        #0.5;
        push(ecnt, "async_rst_immediate", 2'd0, '0, '0);
        check_edge();
        pll_locked = lock_lvl;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        rst  = 1'b0;
        ecnt = 0;
        push(0, "after_release", 2'd0, '0, '0);
        check_edge();
    endtask

    task automatic scen1(output int run_e);
        push(RST_PULSE - 1, "s1_pll_rst_hold", 2'd0, '0, '0);
        push(RST_PULSE,     "s1_wait_lock",    2'd1, '0, '0);
        push(RST_PULSE + 1, "s1_stabilize",    2'd2, '0, '0);
        push(RST_PULSE + LOCK_STABLE,     "s1_still_stab", 2'd2, '0, '0);
        push(RST_PULSE + LOCK_STABLE + 1, "s1_run",        2'd3, '0, '0);
        run_to(RST_PULSE + LOCK_STABLE + 1);
        run_e = RST_PULSE + LOCK_STABLE + 1;
    endtask

    // Lock drops just after edge e; RUN is held through e+2 and left at e+3.
    task automatic lock_loss(input int e, input logic [CW-1:0] llc_before,
                             input logic [CW-1:0] llc_after, input bit with_clr,
                             input bit glitch, output int run_e);
        int g;
        int s;
        run_to(e);
        pll_locked = 1'b0;
        push(e + 2, "loss_still_run", 2'd3, llc_before, '0);
        push(e + 3, "loss_reset_pll", 2'd0, llc_after, '0);
        if (with_clr) begin
            run_to(e + 2);
            clr_cnt = 1'b1;
            run_to(e + 3);
            clr_cnt = 1'b0;
        end else begin
            run_to(e + 3);
        end
        pll_locked = 1'b1;
        push(e + 3 + RST_PULSE - 1, "loss_pulse_end", 2'd0, llc_after, '0);
        push(e + 3 + RST_PULSE,     "loss_wait_lock", 2'd1, llc_after, '0);
        push(e + 4 + RST_PULSE,     "loss_stabilize", 2'd2, llc_after, '0);
        s = e + 4 + RST_PULSE;
        if (glitch) begin
            g = s + 200;
            push(g + 2, "glitch_still_stab", 2'd2, llc_after, '0);
            push(g + 3, "glitch_to_wait",    2'd1, llc_after, '0);
            push(g + 5, "glitch_still_wait", 2'd1, llc_after, '0);
            push(g + 6, "glitch_restab",     2'd2, llc_after, '0);
            run_to(g);
            pll_locked = 1'b0;
            run_to(g + 3);
            pll_locked = 1'b1;
            s = g + 6;
        end
        push(s + LOCK_STABLE - 1, "relock_still_stab", 2'd2, llc_after, '0);
        push(s + LOCK_STABLE,     "relock_run",        2'd3, llc_after, '0);
        run_to(s + LOCK_STABLE);
        run_e = s + LOCK_STABLE;
    endtask

    initial begin
        exp_t it;
        rst        = 1'b1;
        pll_locked = 1'b0;
        clr_cnt    = 1'b0;
        ecnt       = 0;
        n_assert   = 0;
        n_fail     = 0;

        #5;
        push(0, "reset_hold", 2'd0, '0, '0);
        check_edge();
        @(negedge refclk);
        rst = 1'b0;
        push(0, "reset_release", 2'd0, '0, '0);
        check_edge();

        // No lock at all: repeated WAIT_LOCK timeouts.
        push(63,  "to_pulse_end",    2'd0, 2'd0, 2'd0);
        push(64,  "to_wait_entry",   2'd1, 2'd0, 2'd0);
        push(163, "to_wait_last",    2'd1, 2'd0, 2'd0);
        push(164, "to_first",        2'd0, 2'd0, 2'd1);
        push(227, "to_pulse2_end",   2'd0, 2'd0, 2'd1);
        push(228, "to_wait2_entry",  2'd1, 2'd0, 2'd1);
        push(327, "to_wait2_last",   2'd1, 2'd0, 2'd1);
        push(328, "to_second",       2'd0, 2'd0, 2'd2);
        run_to(340);

        // Async reset clears counters immediately; then clean lock sequence.
        async_reset(1'b1);
        scen1(r_run);

        lock_loss(r_run + 100, 2'd0, 2'd1, 1'b0, 1'b0, r_run);
        lock_loss(r_run + 100, 2'd1, 2'd2, 1'b0, 1'b1, r_run);
        lock_loss(r_run + 100, 2'd2, 2'd3, 1'b0, 1'b0, r_run);
        lock_loss(r_run + 100, 2'd3, 2'd3, 1'b0, 1'b0, r_run);
        lock_loss(r_run + 100, 2'd3, 2'd3, 1'b0, 1'b0, r_run);
        lock_loss(r_run + 100, 2'd3, 2'd0, 1'b1, 1'b0, r_run);
        lock_loss(r_run + 100, 2'd0, 2'd1, 1'b0, 1'b0, r_run);

        run_to(r_run + 50);
        async_reset(1'b1);
        scen1(r_run);

        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            n_assert++;
            assert (it.edge_n <= ecnt) else begin
                n_fail++;
                $error("FAIL %s: never reached, at edge %0d expected %b at edge %0d",
                       it.tag, ecnt, it.exp, it.edge_n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cds_data_pll_rst_seq.md
Name: cds_data_pll_rst_seq

Overview:
Reset sequencer and lock supervisor for the CDS data-capture PLL. Runs on the free-running 250 MHz reference clock and drives the PLL reset input. Consumes the PLL locked output and releases the downstream data-capture reset only after lock has been continuously stable. On lock loss or lock timeout it re-pulses the PLL reset and counts the events for slow-control readout.

Parameters:
RST_PULSE_CYCLES, 64, refclk cycles that pll_rst is held high per PLL reset pulse (min 2)
LOCK_STABLE_CYCLES, 1024, consecutive cycles synchronized lock must stay high before release (min 1)
LOCK_TIMEOUT_CYCLES, 262144, cycles allowed in WAIT_LOCK before the PLL is reset again (min 2)
CNT_W, 16, width of the lock_loss_cnt and timeout_cnt event counters

Ports:
refclk  in  1  free-running 250 MHz clock; sole clock of the block
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
clr_cnt  in  1  synchronous clear of both event counters
pll_rst  out  1  reset to PLL, active-high
data_rst  out  1  reset to downstream data-capture logic, active-high
ready  out  1  high only in RUN
state  out  2  0=RESET_PLL 1=WAIT_LOCK 2=STABILIZE 3=RUN
lock_loss_cnt  out  CNT_W  RUN-state lock losses, saturating
timeout_cnt  out  CNT_W  WAIT_LOCK timeouts, saturating

Behaviour:
- Cycle convention: edge k = kth refclk rising edge after rst falls.
- Reset values (applied asynchronously while rst=1): state=RESET_PLL, pll_rst=1, data_rst=1, ready=0, both counters 0, synchronizer flops 0, cycle counter 0.
- pll_locked passes through a 2-flop synchronizer to give locked_s, adding 2 cycles of latency. No other logic samples pll_locked.
- One shared cycle counter, wide enough for the largest parameter. It clears on every state change.
- A state entered at edge k with dwell N is left at edge k+N. Reset counts as entry at edge 0.
- RESET_PLL: dwell exactly RST_PULSE_CYCLES, then go to WAIT_LOCK unconditionally. locked_s is ignored.
- WAIT_LOCK:
  - locked_s=1 at an edge moves to STABILIZE on that edge.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles, go to RESET_PLL and increment timeout_cnt.
- STABILIZE:
  - locked_s=0 at any edge returns to WAIT_LOCK. No counter increments.
  - After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
- RUN: stay while locked_s=1. locked_s=0 moves to RESET_PLL and increments lock_loss_cnt.
- Outputs are registered from the next-state decode, so they change on the same edge as state:
  - pll_rst = (state==RESET_PLL)
  - data_rst = (state!=RUN)
  - ready = (state==RUN)
  - No combinational glitches on any output.
- Event counters saturate at all-ones and never wrap.
- clr_cnt=1 zeroes both counters on the next edge. If clr_cnt coincides with an increment, clear wins and the result is 0.
- Asynchronous rst asserted mid-operation, including in RUN, forces all reset values immediately, without waiting for a clock edge. The sequence restarts from RESET_PLL when rst falls.
- Worst-case detection latency from pll_locked falling to data_rst rising is 3 edges: 2 synchronizer + 1 state.

Test Plan:
1. Defaults, pll_locked=1 throughout -> pll_rst falls at edge 64; STABILIZE at edge 65; data_rst falls and ready rises at edge 1089; both counters 0.
2. LOCK_TIMEOUT_CYCLES=100, pll_locked=0 -> WAIT_LOCK entered at edge 64, left at edge 164; pll_rst high edges 164–227; timeout_cnt=1, then 2 after the next timeout.
3. Lock at start, then pll_locked low for 3 cycles starting edge 500 -> return to WAIT_LOCK, no counter change. After relock, ready rises exactly 1024 cycles after re-entering STABILIZE.
4. Steady RUN, pll_locked falls at edge E -> data_rst=1, ready=0, pll_rst=1 at edge E+3; lock_loss_cnt=1; RUN regained 64+1+1024 cycles later if lock returns.
5. CNT_W=2 with 5 lock losses -> lock_loss_cnt holds 3. clr_cnt pulsed on the same edge as a 6th loss -> count reads 0.
6. rst pulsed asynchronously (between edges) while in RUN -> pll_rst=1, data_rst=1, ready=0, state=0 immediately; counters 0; after release the scenario 1 timing repeats.
